// File: rtl/muldiv_hilo_if.sv
// Execute-stage multiply/divide and HI/LO control/data bundle.
// The decode/execute side drives the controls; the md unit returns the
// HI/LO read data and its busy/stall status.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             mdstart;
    logic             signedop;
    logic             muldivb;
    logic             hilosrc;
    logic [1:0]       hilodisable;
    logic             hiloread;
    logic             hilosel;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] hiloout;
    logic             mdbusy;
    logic             mdstall;

    modport master (
        output valid, mdstart, signedop, muldivb, hilosrc, hilodisable,
               hiloread, hilosel, srca, srcb,
        input  hiloout, mdbusy, mdstall
    );

    modport slave (
        input  valid, mdstart, signedop, muldivb, hilosrc, hilodisable,
               hiloread, hilosel, srca, srcb,
        output hiloout, mdbusy, mdstall
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative radix-2 multiply/divide unit with the architectural HI/LO pair.
// Operands are made magnitude-only at start, WIDTH shift-add or restoring
// shift-subtract steps follow, and signs are restored in a final FIX cycle
// that also commits HI/LO.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_RUN    = 2'd1;
    localparam logic [1:0]    S_FIX    = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic [WIDTH-1:0] acc_q,     acc_d;     // partial product high half / remainder
    logic [WIDTH-1:0] wq_q,      wq_d;      // multiplier / dividend-quotient shifter
    logic [WIDTH-1:0] opb_q,     opb_d;     // |multiplicand| or |divisor|
    logic [WIDTH-1:0] orig_a_q,  orig_a_d;  // raw srca, returned as HI on divide by zero
    logic             is_mul_q,  is_mul_d;
    logic             neg_lo_q,  neg_lo_d;  // product / quotient must be negated
    logic             neg_hi_q,  neg_hi_d;  // remainder must be negated
    logic             dz_q,      dz_d;

    logic             start_s;
    logic             mt_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_abs_s;
    logic [WIDTH-1:0] b_abs_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    // mdstart takes priority; MTxx only commits when no op is launched or running
    assign start_s = bus.valid & bus.mdstart & (state_q == S_IDLE);
    assign mt_s    = bus.valid & bus.hilosrc & ~bus.mdstart & (state_q == S_IDLE);

    assign a_neg_s = bus.signedop & bus.srca[WIDTH-1];
    assign b_neg_s = bus.signedop & bus.srcb[WIDTH-1];
    assign a_abs_s = a_neg_s ? ({WIDTH{1'b0}} - bus.srca) : bus.srca;
    assign b_abs_s = b_neg_s ? ({WIDTH{1'b0}} - bus.srcb) : bus.srcb;

    // Multiply step: conditionally add multiplicand into the high half
    assign sum_s   = {1'b0, acc_q} + (wq_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Divide step: bring in next dividend bit and trial-subtract the divisor
    assign shift_s = {acc_q, wq_q[WIDTH-1]};
    assign ge_s    = (shift_s >= {1'b0, opb_q});
    assign diff_s  = shift_s[WIDTH-1:0] - opb_q;

    assign prod_s     = {acc_q, wq_q};
    assign prod_neg_s = {(2*WIDTH){1'b0}} - prod_s;
    assign quo_fix_s  = neg_lo_q ? ({WIDTH{1'b0}} - wq_q)  : wq_q;
    assign rem_fix_s  = neg_hi_q ? ({WIDTH{1'b0}} - acc_q) : acc_q;

    assign bus.hiloout = bus.hilosel ? lo_q : hi_q;
    assign bus.mdbusy  = (state_q != S_IDLE);
    assign bus.mdstall = bus.valid & bus.mdbusy & (bus.mdstart | bus.hiloread | bus.hilosrc);

    // Next-state logic for the sequencer, datapath and HI/LO
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        wq_d     = wq_q;
        opb_d    = opb_q;
        orig_a_d = orig_a_q;
        is_mul_d = is_mul_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d  = S_RUN;
                    cnt_d    = {CW{1'b0}};
                    acc_d    = {WIDTH{1'b0}};
                    wq_d     = bus.muldivb ? b_abs_s : a_abs_s;
                    opb_d    = bus.muldivb ? a_abs_s : b_abs_s;
                    orig_a_d = bus.srca;
                    is_mul_d = bus.muldivb;
                    neg_lo_d = a_neg_s ^ b_neg_s;
                    neg_hi_d = a_neg_s;
                    dz_d     = (bus.srcb == {WIDTH{1'b0}});
                end else if (mt_s) begin
                    if (!bus.hilodisable[0]) begin
                        hi_d = bus.srca;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (!bus.hilodisable[1]) begin
                        lo_d = bus.srca;
                    end else begin
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (is_mul_q) begin
                    {acc_d, wq_d} = {sum_s, wq_q[WIDTH-1:1]};
                end else if (ge_s) begin
                    acc_d = diff_s;
                    wq_d  = {wq_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shift_s[WIDTH-1:0];
                    wq_d  = {wq_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (is_mul_q) begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg_s : prod_s;
                end else if (dz_q) begin
                    hi_d = orig_a_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and HI/LO registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            wq_q     <= {WIDTH{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            orig_a_q <= {WIDTH{1'b0}};
            is_mul_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            wq_q     <= wq_d;
            opb_q    <= opb_d;
            orig_a_q <= orig_a_d;
            is_mul_q <= is_mul_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: stimulus updates an arithmetic HI/LO
// model and queues the expected data of every MFHI/MFLO it issues; a
// monitor compares each committed read against the queue.
module tb_muldiv_hilo;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_hilo_if #(.WIDTH(W)) bus ();
    muldiv_hilo #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero
    function automatic logic [63:0] ref_op(input bit sgn, input bit mul,
                                           input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (mul) begin
            res = 64'(sa * sb);
        end else if (b == 32'h0) begin
            res = {a, 32'hFFFFFFFF};
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Monitor: a read instruction commits in a cycle where it is valid and not stalled
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.valid === 1'b1 && bus.hiloread === 1'b1 && bus.mdstall === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_read: got %h expected no read", bus.hiloout);
            end else begin
                check(name_q.pop_front(), bus.hiloout, exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        bus.valid = 1'b0; bus.mdstart = 1'b0; bus.signedop = 1'b0; bus.muldivb = 1'b0;
        bus.hilosrc = 1'b0; bus.hilodisable = 2'b00; bus.hiloread = 1'b0;
        bus.hilosel = 1'b0; bus.srca = 32'h0; bus.srcb = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch an md op in cycle 0; returns in cycle 1
    task automatic issue_md(input bit sgn, input bit mul, input logic [31:0] a,
                            input logic [31:0] b, input bit also_mt);
        bus.valid = 1'b1; bus.mdstart = 1'b1; bus.signedop = sgn; bus.muldivb = mul;
        bus.srca = a; bus.srcb = b; bus.hilosrc = also_mt; bus.hilodisable = 2'b00;
        {m_hi, m_lo} = ref_op(sgn, mul, a, b);
        step();
        idle_inputs();
        check_bit("busy_cycle1", bus.mdbusy, 1'b1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.mdbusy && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic do_read(input bit sel, output int stalls);
        bus.valid = 1'b1; bus.hiloread = 1'b1; bus.hilosel = sel;
        exp_q.push_back(sel ? m_lo : m_hi);
        name_q.push_back(sel ? "read_lo" : "read_hi");
        #1;
        stalls = 0;
        while (bus.mdstall && stalls < 200) begin
            step();
            stalls++;
        end
        if (stalls >= 200) begin
            n_total++;
            $display("FAIL read_stall_timeout: got %0d stall cycles expected fewer than 200", stalls);
        end
        step();
        idle_inputs();
    endtask

    task automatic do_mt(input logic [1:0] dis, input logic [31:0] data);
        bus.valid = 1'b1; bus.hilosrc = 1'b1; bus.hilodisable = dis; bus.srca = data;
        #1;
        check_bit("mt_no_stall", bus.mdstall, 1'b0);
        step();
        idle_inputs();
        check_bit("mt_no_busy", bus.mdbusy, 1'b0);
        if (!dis[0]) m_hi = data;
        if (!dis[1]) m_lo = data;
    endtask

    task automatic full_op(input bit sgn, input bit mul, input logic [31:0] a,
                           input logic [31:0] b, input bit also_mt);
        int n;
        int s;
        issue_md(sgn, mul, a, b, also_mt);
        wait_idle(n);
        check("busy_cycles", 32'(n), 32'd33);
        do_read(1'b0, s);
        do_read(1'b1, s);
    endtask

    initial begin
        int          n;
        int          s;
        bit          sgn;
        bit          mul;
        logic [31:0] a;
        logic [31:0] b;

        idle_inputs();
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_busy", bus.mdbusy, 1'b0);
        check_bit("reset_stall", bus.mdstall, 1'b0);
        check("reset_hiloout", bus.hiloout, 32'h0);
        reset = 1'b0;
        step();

        // Directed operations
        full_op(1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        full_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        full_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        full_op(1'b0, 1'b0, 32'h00000007, 32'h00000000, 1'b0);
        full_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        full_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000000, 1'b0);
        // mdstart together with hilosrc: the MTxx write is dropped
        full_op(1'b0, 1'b1, 32'h00001234, 32'h00000010, 1'b1);

        // MFLO issued in cycle 5 stalls through cycle 33
        issue_md(1'b1, 1'b1, 32'h00000055, 32'hFFFFFF00, 1'b0);
        bus.hiloread = 1'b1;
        #1;
        check_bit("stall_needs_valid", bus.mdstall, 1'b0);
        bus.hiloread = 1'b0; bus.valid = 1'b1; bus.mdstart = 1'b1;
        #1;
        check_bit("stall_on_mdstart", bus.mdstall, 1'b1);
        idle_inputs();
        repeat (3) step();
        step();
        do_read(1'b1, s);
        check("mflo_stall_cycles", 32'(s), 32'd29);
        check_bit("idle_after_read", bus.mdbusy, 1'b0);
        do_read(1'b0, s);

        // MTHI then MTLO
        do_mt(2'b10, 32'h12345678);
        do_read(1'b0, s);
        do_read(1'b1, s);
        do_mt(2'b01, 32'hCAFEF00D);
        do_read(1'b0, s);
        do_read(1'b1, s);

        // Asynchronous reset in cycle 10 of a divide
        issue_md(1'b1, 1'b0, 32'h00000064, 32'h00000007, 1'b0);
        repeat (9) step();
        reset = 1'b1;
        #1;
        m_hi = 32'h0;
        m_lo = 32'h0;
        check_bit("async_reset_busy", bus.mdbusy, 1'b0);
        bus.hilosel = 1'b0;
        #1;
        check("async_reset_hi", bus.hiloout, 32'h0);
        bus.hilosel = 1'b1;
        #1;
        check("async_reset_lo", bus.hiloout, 32'h0);
        step();
        reset = 1'b0;
        idle_inputs();
        step();
        full_op(1'b0, 1'b1, 32'h00010001, 32'h00020003, 1'b0);

        // Randomized operations with corner operands mixed in
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            mul = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 6))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = 32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) do_mt(($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01, $urandom);
            full_op(sgn, mul, a, b, 1'b0);
        end

        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
